async_fifo_single_clk: RTL and testbench



---
 rtl/async_fifo_single_clk.sv | 93 +++++++++
 tb/tb_async_fifo_single_clk.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/async_fifo_single_clk.sv
// Single-clock FIFO with the async_fifo port set, first-word-fall-through read data and registered flags.
// Optional sticky overflow/underflow outputs werr/rerr are enabled by defining ASYNC_FIFO_ERR_FLAGS_EN.
module async_fifo_single_clk #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic             werr,
    output logic             rerr
`endif
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] PTR_ONE   = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] CNT_EMPTY = '0;
    localparam logic [ASIZE:0] CNT_ONE   = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] CNT_FULL  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] CNT_AFULL = (ASIZE+1)'(DEPTH - 1);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   wptr_next;
    logic [ASIZE:0]   rptr_next;
    logic [ASIZE:0]   count_next;
    logic             w_acc;
    logic             r_acc;

    assign w_acc = winc && !wfull;
    assign r_acc = rinc && !rempty;

    always_comb begin
        wptr_next  = w_acc ? (wptr + PTR_ONE) : wptr;
        rptr_next  = r_acc ? (rptr + PTR_ONE) : rptr;
        count_next = wptr_next - rptr_next;
    end

    // RAM is intentionally left out of reset; rdata is don't-care while empty.
    always_ff @(posedge wclk) begin
        if (w_acc) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rptr[ASIZE-1:0]];

    // Flags come from next-state pointers so they track this edge's accepted ops.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            wfull   <= 1'b0;
            awfull  <= 1'b0;
            arempty <= 1'b0;
        end else begin
            wptr    <= wptr_next;
            rptr    <= rptr_next;
            rempty  <= (count_next == CNT_EMPTY);
            wfull   <= (count_next == CNT_FULL);
            awfull  <= (count_next == CNT_AFULL);
            arempty <= (count_next == CNT_ONE);
        end
    end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            werr <= 1'b0;
            rerr <= 1'b0;
        end else begin
            if (winc && wfull) begin
                werr <= 1'b1;
            end
            if (rinc && rempty) begin
                rerr <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_single_clk.sv
// Directed self-checking bench for async_fifo_single_clk (DSIZE=32, ASIZE=4).
// Define ASYNC_FIFO_ERR_FLAGS_EN for both files to also cover werr/rerr.
module tb_async_fifo_single_clk;

    localparam int DSIZE = 32;
    localparam int ASIZE = 4;

    logic             wclk   = 1'b0;
    logic             wrst_n = 1'b0;
    logic             winc   = 1'b0;
    logic             rinc   = 1'b0;
    logic [DSIZE-1:0] wdata  = '0;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             awfull;
    logic             rempty;
    logic             arempty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic             werr;
    logic             rerr;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    async_fifo_single_clk #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .winc    (winc),
        .wdata   (wdata),
        .wfull   (wfull),
        .awfull  (awfull),
        .rinc    (rinc),
        .rdata   (rdata),
        .rempty  (rempty),
        .arempty (arempty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        ,
        .werr    (werr),
        .rerr    (rerr)
`endif
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one cycle of requests, then sample 1 ns after the edge.
    task automatic step(input logic w, input logic [31:0] d, input logic r);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge wclk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    initial begin
        int q[$];
        int v;

        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b1;
        step(1'b0, 0, 1'b0);

        chk("idle_wfull",   wfull,   1'b0);
        chk("idle_rempty",  rempty,  1'b1);
        chk("idle_awfull",  awfull,  1'b0);
        chk("idle_arempty", arempty, 1'b0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("idle_werr", werr, 1'b0);
        chk("idle_rerr", rerr, 1'b0);
`endif

        step(1'b1, 32'hA, 1'b0);
        chk("single_rempty",  rempty,  1'b0);
        chk("single_arempty", arempty, 1'b1);
        chk("single_rdata",   rdata,   32'hA);
        step(1'b0, 0, 1'b1);
        chk("single_pop_rempty",  rempty,  1'b1);
        chk("single_pop_arempty", arempty, 1'b0);

        for (int i = 0; i < 10; i++) step(1'b1, i, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("burst_rdata", rdata, i);
            step(1'b0, 0, 1'b1);
        end
        chk("burst_rempty", rempty, 1'b1);

        // Pointers sit at 11 here, so filling to full also crosses the wrap.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i, 1'b0);
            if (i == 14) begin
                chk("fill15_awfull", awfull, 1'b1);
                chk("fill15_wfull",  wfull,  1'b0);
            end
        end
        chk("fill16_wfull",  wfull,  1'b1);
        chk("fill16_awfull", awfull, 1'b0);
        step(1'b1, 32'hFF, 1'b0);
        chk("overflow_wfull", wfull, 1'b1);
        chk("overflow_head",  rdata, 0);

        step(1'b1, 32'hEE, 1'b1);
        chk("full_rw_wfull",  wfull,  1'b0);
        chk("full_rw_awfull", awfull, 1'b1);
        for (int i = 1; i < 16; i++) begin
            chk("drain_rdata", rdata, i);
            step(1'b0, 0, 1'b1);
        end
        chk("drain_rempty", rempty, 1'b1);

        step(1'b1, 32'h55, 1'b1);
        chk("empty_rw_rempty",  rempty,  1'b0);
        chk("empty_rw_arempty", arempty, 1'b1);
        chk("empty_rw_rdata",   rdata,   32'h55);
        step(1'b0, 0, 1'b1);
        chk("empty_rw_pop", rempty, 1'b1);

        v = 100;
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 0; i < 8; i++) begin
                step(1'b1, v, 1'b0);
                q.push_back(v);
                v++;
            end
            for (int i = 0; i < 16; i++) begin
                chk("wrap_rw_rdata", rdata, q[0]);
                step(1'b1, v, 1'b1);
                void'(q.pop_front());
                q.push_back(v);
                v++;
                chk("wrap_rw_wfull",  wfull,  1'b0);
                chk("wrap_rw_rempty", rempty, 1'b0);
            end
            while (q.size() > 0) begin
                chk("wrap_drain_rdata", rdata, q[0]);
                step(1'b0, 0, 1'b1);
                void'(q.pop_front());
            end
            chk("wrap_rempty", rempty, 1'b1);
        end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("sticky_werr", werr, 1'b1);
        chk("sticky_rerr", rerr, 1'b1);
`endif

        for (int i = 0; i < 3; i++) step(1'b1, i, 1'b0);
        chk("pre_reset_rempty", rempty, 1'b0);
        #2 wrst_n = 1'b0;
        #1;
        chk("async_reset_rempty",  rempty,  1'b1);
        chk("async_reset_arempty", arempty, 1'b0);
        chk("async_reset_wfull",   wfull,   1'b0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("async_reset_werr", werr, 1'b0);
        chk("async_reset_rerr", rerr, 1'b0);
`endif
        @(negedge wclk);
        wrst_n = 1'b1;
        step(1'b0, 0, 1'b0);
        chk("post_reset_rempty", rempty, 1'b1);
        step(1'b1, 32'h77, 1'b0);
        chk("post_reset_rdata",   rdata,   32'h77);
        chk("post_reset_arempty", arempty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
